// File: rtl/enc_pkg.sv
// Shared encoder/decoder definitions: default widths, the no-one-hot code and a
// lowest-set-bit helper used by the one-hot to binary decoder.
package enc_pkg;

  localparam int unsigned ENC_OH_WIDTH  = 15;
  localparam int unsigned ENC_BIN_WIDTH = 4;

  localparam logic [ENC_BIN_WIDTH-1:0] ENC_NO_ONEHOT = 4'hF;

  typedef struct packed {
    logic [ENC_BIN_WIDTH-1:0] idx;
    logic                     zero;
    logic                     multi;
  } enc_dec_t;

  // Index of the lowest set bit; ENC_NO_ONEHOT when no bit is set.
  function automatic enc_dec_t onehot_lowest_idx(input logic [ENC_OH_WIDTH-1:0] vec);
    enc_dec_t res;
    logic     found;
    res.idx   = ENC_NO_ONEHOT;
    res.zero  = (vec == '0);
    res.multi = 1'b0;
    found     = 1'b0;
    for (int k = 0; k < int'(ENC_OH_WIDTH); k++) begin
      if (vec[k]) begin
        if (found) begin
          res.multi = 1'b1;
        end else begin
          res.idx = ENC_BIN_WIDTH'(k);
        end
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/enc_onehot2bin_core.sv
// Purely combinational one-hot decode: lowest-bit index plus zero and multi-hot flags.
module enc_onehot2bin_core
  import enc_pkg::*;
(
  input  logic [ENC_OH_WIDTH-1:0]  oh,
  output logic [ENC_BIN_WIDTH-1:0] idx,
  output logic                     zero,
  output logic                     multi
);

  enc_dec_t dec;

  assign dec   = onehot_lowest_idx(oh);
  assign idx   = dec.idx;
  assign zero  = dec.zero;
  assign multi = dec.multi;

endmodule

// File: rtl/enc_onehot2bin.sv
// Registered one-hot to binary decoder with valid/ready on both sides, illegal-code
// flag and a saturating error counter.
module enc_onehot2bin
  import enc_pkg::*;
#(
  parameter int unsigned OH_WIDTH  = ENC_OH_WIDTH,
  parameter int unsigned BIN_WIDTH = ENC_BIN_WIDTH,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OH_WIDTH-1:0]  in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIN_WIDTH-1:0] out,
  output logic                 out_err,
  output logic [CNT_WIDTH-1:0] err_cnt,
  input  logic                 err_clr
);

  logic [BIN_WIDTH-1:0] dec_idx;
  logic                 dec_zero;
  logic                 dec_multi;
  logic                 dec_err;
  logic                 accept;

  logic                 valid_q;
  logic [BIN_WIDTH-1:0] out_q;
  logic                 err_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  enc_onehot2bin_core u_core (
    .oh    (in),
    .idx   (dec_idx),
    .zero  (dec_zero),
    .multi (dec_multi)
  );

  assign dec_err  = dec_zero | dec_multi;
  // 1-deep skid-free stage: a draining output frees the register in the same cycle.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      out_q   <= dec_idx;
      err_q   <= dec_err;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Clear beats a same-cycle error; saturate instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (err_clr) begin
      cnt_d = '0;
    end else if (accept && dec_err && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out       = out_q;
  assign out_err   = err_q;
  assign err_cnt   = cnt_q;

endmodule
